// File: rtl/cim_pkg.sv
// -----------------------------------------------------------------------------
// cim_pkg
// Shared definitions for the CIM array front-end and the array decoder:
//   - array op codes (MAC, write, query, NOP)
//   - array address/data widths and address field positions
//   - command sequencer state encoding and latched-command record
//   - beat_addr(): burst beat address with natural wrap at the array size
// -----------------------------------------------------------------------------
package cim_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  // Address layout: bank[8:5], row[4:3], col[2:0]
  localparam int BANK_MSB = 8;
  localparam int BANK_LSB = 5;
  localparam int ROW_MSB  = 4;
  localparam int ROW_LSB  = 3;
  localparam int COL_MSB  = 2;
  localparam int COL_LSB  = 0;

  typedef enum logic [1:0] {
    OP_MAC = 2'b00,
    OP_WR  = 2'b01,
    OP_QRY = 2'b10,
    OP_NOP = 2'b11
  } cim_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WBURST
  } seq_state_e;

  // Fields of an accepted command that are still needed after the accept
  // cycle. MAC operand and mask are consumed at the accept edge, so they are
  // not part of this record.
  typedef struct packed {
    cim_op_e             op;
    logic [ADDR_W-1:0]   addr;
    logic [3:0]          len;
  } cim_cmd_t;

  // Address of a burst beat; the sum truncates to ADDR_W bits so the last
  // array location wraps to 0.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [3:0]        beat);
    return base + {{(ADDR_W-4){1'b0}}, beat};
  endfunction

endpackage

// File: rtl/cim_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// cim_cmd_sequencer
// Command front-end for the CIM array. Accepts MAC / query / write-burst / NOP
// commands over a valid/ready interface, drives the array decoder inputs,
// expands write bursts into one array write per beat, waits out the array
// result latency and returns one done pulse per command.
//
// Parameters
//   RES_LAT      cycles from array issue to stable MAC/query result (1..15)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         host command handshake (ready only when idle)
//   cmd_op/addr/len/data/mask   command fields (len = beats-1, writes only)
//   wdata_valid/wdata_ready     write beat handshake (ready only in a burst)
//   wdata                       write beat data (8 bits, zero-extended)
//   op_code/addr/data_bank/data_in   registered decoder drive
//   busy                        sequencer not idle
//   done_valid/done_op          one-cycle completion pulse and its op
// -----------------------------------------------------------------------------
module cim_cmd_sequencer
  import cim_pkg::*;
#(
  parameter int RES_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_mask,

  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [7:0]        wdata,

  output logic [1:0]        op_code,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_bank,
  output logic [DATA_W-1:0] data_in,

  output logic              busy,
  output logic              done_valid,
  output logic [1:0]        done_op
);

  localparam logic [3:0] LAT_LOAD = 4'(RES_LAT - 1);

  seq_state_e state, state_next;
  cim_cmd_t   cmd_q;
  // Shared counter: beat index in WBURST, remaining latency in WAIT.
  logic [3:0] cnt;

  // Registered decoder drive and completion outputs, with their next values.
  cim_op_e           op_code_q,    op_code_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DATA_W-1:0] data_bank_q,  data_bank_d;
  logic [DATA_W-1:0] data_in_q,    data_in_d;
  logic              done_valid_q, done_valid_d;
  cim_op_e           done_op_q,    done_op_d;

  cim_op_e cmd_op_e;
  logic    cmd_fire;
  logic    beat_fire;
  logic    last_beat;
  logic    lat_done;

  assign cmd_op_e  = cim_op_e'(cmd_op);
  // Handshakes are decoded straight from state so they do not depend on the
  // ready outputs; this keeps the combinational graph free of loops.
  assign cmd_fire  = cmd_valid   && (state == ST_IDLE);
  assign beat_fire = wdata_valid && (state == ST_WBURST);
  assign last_beat = beat_fire   && (cnt == cmd_q.len);
  assign lat_done  = (state == ST_WAIT) && (cnt == 4'd0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in a combinational block gets a default at
  // the top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          unique case (cmd_op_e)
            OP_MAC, OP_QRY: state_next = ST_ISSUE;
            OP_WR:          state_next = ST_WBURST;
            OP_NOP:         state_next = ST_IDLE;
            default:        state_next = ST_IDLE;
          endcase
        end
      end
      ST_ISSUE:  state_next = ST_WAIT;
      ST_WAIT:   if (lat_done)  state_next = ST_IDLE;
      ST_WBURST: if (last_beat) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch and shared beat/latency counter
  // ---------------------------------------------------------------------------
  // NOTE: the command latch and counter are plain flops (no memory array), so
  // they are all reset; an abandoned command leaves no stale state behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '{op: OP_NOP, addr: '0, len: '0};
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            cmd_q <= '{op: cmd_op_e, addr: cmd_addr, len: cmd_len};
            cnt   <= '0;
          end
        end
        ST_ISSUE:  cnt <= LAT_LOAD;
        ST_WAIT:   if (cnt != 4'd0) cnt <= cnt - 4'd1;
        ST_WBURST: if (beat_fire)   cnt <= cnt + 4'd1;
        default:   cnt <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // The decoder drive is registered, so the value that must appear during the
  // ISSUE cycle is computed from the command inputs at the accept edge, and a
  // burst write appears the cycle after its beat handshake.
  // ---------------------------------------------------------------------------
  assign cmd_ready   = (state == ST_IDLE);
  assign wdata_ready = (state == ST_WBURST);
  assign busy        = (state != ST_IDLE);

  always_comb begin
    op_code_d    = OP_NOP;
    addr_d       = '0;
    data_bank_d  = '0;
    data_in_d    = '0;
    done_valid_d = 1'b0;
    done_op_d    = done_op_q;
    unique case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          unique case (cmd_op_e)
            OP_MAC: begin
              op_code_d   = OP_MAC;
              addr_d      = cmd_addr;
              data_bank_d = cmd_data;
              data_in_d   = cmd_mask;
            end
            OP_QRY: begin
              op_code_d   = OP_QRY;
              addr_d      = cmd_addr;
              data_bank_d = cmd_data;
            end
            OP_NOP: begin
              done_valid_d = 1'b1;
              done_op_d    = OP_NOP;
            end
            default: ;
          endcase
        end
      end
      ST_WAIT: begin
        if (lat_done) begin
          done_valid_d = 1'b1;
          done_op_d    = cmd_q.op;
        end
      end
      ST_WBURST: begin
        if (beat_fire) begin
          op_code_d   = OP_WR;
          addr_d      = beat_addr(cmd_q.addr, cnt);
          data_bank_d = {8'h00, wdata};
        end
        // The done pulse lines up with the last write on the decoder inputs.
        if (last_beat) begin
          done_valid_d = 1'b1;
          done_op_d    = OP_WR;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_code_q    <= OP_NOP;
      addr_q       <= '0;
      data_bank_q  <= '0;
      data_in_q    <= '0;
      done_valid_q <= 1'b0;
      done_op_q    <= OP_NOP;
    end else begin
      op_code_q    <= op_code_d;
      addr_q       <= addr_d;
      data_bank_q  <= data_bank_d;
      data_in_q    <= data_in_d;
      done_valid_q <= done_valid_d;
      done_op_q    <= done_op_d;
    end
  end

  assign op_code    = op_code_q;
  assign addr       = addr_q;
  assign data_bank  = data_bank_q;
  assign data_in    = data_in_q;
  assign done_valid = done_valid_q;
  assign done_op    = done_op_q;

endmodule
